// File: rtl/floo_wrr_lock_arbiter.sv
// Weighted round-robin arbiter with packet locking and a valid/ready grant toward the downstream port.
// Optional per-input tail-flit counters (pkt_cnt_o) are enabled by defining FLOO_ARB_PKT_CNT_EN.
module floo_wrr_lock_arbiter #(
  parameter int unsigned NumInputs   = 4,
  parameter int unsigned WeightWidth = 3,
  parameter int unsigned CntWidth    = 16,
  localparam int unsigned NumInputsWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumInputs-1:0]             req_i,
  input  logic [NumInputs-1:0]             last_i,
  input  logic [NumInputs*WeightWidth-1:0] weight_i,
  input  logic                             ready_i,
  output logic                             valid_o,
  output logic [NumInputs-1:0]             grant_o,
  output logic [NumInputsWidth-1:0]        grant_id_o,
  output logic                             locked_o
`ifdef FLOO_ARB_PKT_CNT_EN
  ,
  output logic [NumInputs*CntWidth-1:0]    pkt_cnt_o
`endif
);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_state_e;

  lock_state_e                state_q, state_d;
  logic [NumInputsWidth-1:0]  ptr_q, ptr_d;
  logic [WeightWidth-1:0]     cnt_q, cnt_d;
  logic [NumInputsWidth-1:0]  lock_id_q, lock_id_d;

  logic [NumInputsWidth-1:0]  sel_id;
  logic                       sel_hit;
  logic [NumInputsWidth-1:0]  cand_id;
  logic [NumInputs-1:0]       grant;
  logic                       valid;
  logic                       last_g;
  logic                       fire;
  logic [WeightWidth-1:0]     w_g;
  logic [WeightWidth-1:0]     eff_w;
  logic [WeightWidth:0]       tmp;
  int unsigned                idx;

  // Rotating scan from ptr_q; the index is folded back below NumInputs so
  // non-power-of-2 sizes never address a nonexistent input.
  always_comb begin
    sel_id  = '0;
    sel_hit = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NumInputs; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NumInputs) idx = idx - NumInputs;
      if (!sel_hit && req_i[idx[NumInputsWidth-1:0]]) begin
        sel_hit = 1'b1;
        sel_id  = idx[NumInputsWidth-1:0];
      end
    end

    cand_id = (state_q == LOCKED) ? lock_id_q : sel_id;

    grant = '0;
    w_g   = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      if (cand_id == NumInputsWidth'(i)) begin
        grant[i] = req_i[i];
        w_g      = weight_i[i*WeightWidth +: WeightWidth];
      end
    end

    valid  = |grant;
    last_g = |(grant & last_i);
  end

  assign fire       = valid & ready_i;
  assign valid_o    = valid;
  assign grant_o    = grant;
  assign grant_id_o = valid ? cand_id : '0;
  assign locked_o   = (state_q == LOCKED);
  assign eff_w      = (w_g == '0) ? WeightWidth'(1) : w_g;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tmp       = '0;
    if (fire) begin
      if (!last_g) begin
        state_d   = LOCKED;
        lock_id_d = cand_id;
      end else begin
        state_d = UNLOCKED;
        // One bit wider than cnt_q so a full-weight count cannot wrap.
        tmp = (cand_id == ptr_q) ? ({1'b0, cnt_q} + (WeightWidth+1)'(1))
                                 : (WeightWidth+1)'(1);
        if (tmp >= {1'b0, eff_w}) begin
          ptr_d = (cand_id == NumInputsWidth'(NumInputs-1)) ? '0
                                                            : cand_id + NumInputsWidth'(1);
          cnt_d = '0;
        end else begin
          ptr_d = cand_id;
          cnt_d = tmp[WeightWidth-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= UNLOCKED;
      ptr_q     <= '0;
      cnt_q     <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      lock_id_q <= lock_id_d;
    end
  end

`ifdef FLOO_ARB_PKT_CNT_EN
  logic [CntWidth-1:0] pkt_cnt_q [NumInputs];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumInputs; i++) pkt_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumInputs; i++) begin
        if (fire && last_g && grant[i] && (pkt_cnt_q[i] != '1))
          pkt_cnt_q[i] <= pkt_cnt_q[i] + CntWidth'(1);
      end
    end
  end

  always_comb begin
    pkt_cnt_o = '0;
    for (int unsigned i = 0; i < NumInputs; i++)
      pkt_cnt_o[i*CntWidth +: CntWidth] = pkt_cnt_q[i];
  end
`else
  // CntWidth only sizes the optional counters.
  logic unused_cnt_width;
  assign unused_cnt_width = (CntWidth != 0);
`endif

endmodule

// File: tb/tb_floo_wrr_lock_arbiter.sv
// Directed bench for floo_wrr_lock_arbiter: expected grants are queued when stimulus
// is applied and checked with immediate assertions when the outputs are sampled.
module tb_floo_wrr_lock_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic [3:0]  req_i;
  logic [3:0]  last_i;
  logic [11:0] weight_i;
  logic        ready_i;
  logic        valid_o;
  logic [3:0]  grant_o;
  logic [1:0]  grant_id_o;
  logic        locked_o;
`ifdef FLOO_ARB_PKT_CNT_EN
  logic [63:0] pkt_cnt_o;
`endif

  floo_wrr_lock_arbiter #(
    .NumInputs  (4),
    .WeightWidth(3),
    .CntWidth   (16)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .last_i    (last_i),
    .weight_i  (weight_i),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .grant_o   (grant_o),
    .grant_id_o(grant_id_o),
    .locked_o  (locked_o)
`ifdef FLOO_ARB_PKT_CNT_EN
    ,
    .pkt_cnt_o (pkt_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic       valid;
    logic [3:0] grant;
    logic [1:0] id;
    logic       locked;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push_exp(input string tag, input logic ev, input logic [1:0] eid, input logic elk);
    exp_t e;
    e.tag    = tag;
    e.valid  = ev;
    e.grant  = ev ? (4'b0001 << eid) : 4'b0000;
    e.id     = ev ? eid : 2'd0;
    e.locked = elk;
    exp_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_assert++;
      assert (valid_o === e.valid) else begin
        n_fail++;
        $error("FAIL %s valid_o: observed %0b expected %0b", e.tag, valid_o, e.valid);
      end
      n_assert++;
      assert (grant_o === e.grant) else begin
        n_fail++;
        $error("FAIL %s grant_o: observed %b expected %b", e.tag, grant_o, e.grant);
      end
      n_assert++;
      assert (grant_id_o === e.id) else begin
        n_fail++;
        $error("FAIL %s grant_id_o: observed %0d expected %0d", e.tag, grant_id_o, e.id);
      end
      n_assert++;
      assert (locked_o === e.locked) else begin
        n_fail++;
        $error("FAIL %s locked_o: observed %0b expected %0b", e.tag, locked_o, e.locked);
      end
    end
  endtask

  // Apply inputs just after a rising edge, check on the falling edge, then advance.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] last,
                      input logic rdy, input logic ev, input logic [1:0] eid, input logic elk);
    req_i   = req;
    last_i  = last;
    ready_i = rdy;
    push_exp(tag, ev, eid, elk);
    @(negedge clk_i);
    compare();
    @(posedge clk_i);
    #1;
  endtask

`ifdef FLOO_ARB_PKT_CNT_EN
  task automatic check_cnt(input string tag, input logic [63:0] exp_cnt);
    n_assert++;
    assert (pkt_cnt_o === exp_cnt) else begin
      n_fail++;
      $error("FAIL %s pkt_cnt_o: observed %h expected %h", tag, pkt_cnt_o, exp_cnt);
    end
  endtask
`endif

  logic [1:0] rr_ids [8];
  logic [1:0] wrr_ids [9];

  initial begin
    rr_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    wrr_ids = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};

    rst_ni   = 1'b0;
    req_i    = 4'b0000;
    last_i   = 4'b0000;
    ready_i  = 1'b0;
    // input 3 weight 0 behaves as weight 1
    weight_i = {3'd0, 3'd1, 3'd1, 3'd1};
    #3;
    push_exp("reset_idle", 1'b0, 2'd0, 1'b0);
    compare();
`ifdef FLOO_ARB_PKT_CNT_EN
    check_cnt("reset_cnt", 64'd0);
`endif
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++)
      step("rr", 4'b1111, 4'b1111, 1'b1, 1'b1, rr_ids[i], 1'b0);
`ifdef FLOO_ARB_PKT_CNT_EN
    check_cnt("rr_cnt", {16'd2, 16'd2, 16'd2, 16'd2});
`endif

    weight_i = {3'd1, 3'd1, 3'd1, 3'd3};
    for (int i = 0; i < 9; i++)
      step("wrr", 4'b1111, 4'b1111, 1'b1, 1'b1, wrr_ids[i], 1'b0);
    weight_i = {3'd1, 3'd1, 3'd1, 3'd1};

    step("pkt_head", 4'b0111, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0);
    step("pkt_body", 4'b0111, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1);
    step("pkt_tail", 4'b0111, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1);
    step("pkt_next", 4'b0101, 4'b0101, 1'b0, 1'b1, 2'd2, 1'b0);

    step("bub_head", 4'b0101, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    step("bubble0",  4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1);
    step("bubble1",  4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1);
    step("bub_tail", 4'b0101, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1);

    for (int i = 0; i < 5; i++)
      step("stall", 4'b0110, 4'b0110, 1'b0, 1'b1, 2'd1, 1'b0);
    step("stall_fire", 4'b0110, 4'b0110, 1'b1, 1'b1, 2'd1, 1'b0);
    step("stall_next", 4'b0110, 4'b0110, 1'b0, 1'b1, 2'd2, 1'b0);

    step("rst_head", 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0);
    step("rst_held", 4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1);
    #2;
    rst_ni = 1'b0;
    push_exp("rst_async", 1'b1, 2'd3, 1'b0);
    #1;
    compare();
    req_i = 4'b1001;
    push_exp("rst_ptr0", 1'b1, 2'd0, 1'b0);
    #1;
    compare();
`ifdef FLOO_ARB_PKT_CNT_EN
    check_cnt("rst_cnt", 64'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step("post_rst", 4'b1001, 4'b1001, 1'b1, 1'b1, 2'd0, 1'b0);
    step("post_rst_next", 4'b1001, 4'b1001, 1'b0, 1'b1, 2'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
